// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/execute operand path.
//   DATA_W     : operand / data width
//   REG_W      : register address width (register 0 reads as zero)
//   fwd_sel_e  : which source supplies an operand
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {
    FWD_RF  = 3'd0,
    FWD_EX  = 3'd1,
    FWD_MEM = 3'd2,
    FWD_WB  = 3'd3,
    FWD_SHD = 3'd4
  } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding selector: priority match against the in-flight
// writers and the matching operand mux. Purely combinational.
// Build option: OPERAND_FWD_EN. When defined, results are forwarded
// (EX > MEM > WB > shadow > register file) and only a load in EX raises a
// hazard. When undefined, the register file value is always used and any
// in-flight writer of the source register raises a hazard.
// Ports:
//   src / src_en / rf_data           source address, use flag, RF read bus
//   ex_* / mem_* / wb_* / shd_*      in-flight writer descriptors and data
//   operand                          selected operand value
//   sel                              selected source
//   hazard                           this operand must wait
module fwd_select #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
  input  logic [REG_W-1:0]  src,
  input  logic              src_en,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_valid,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_valid,
  input  logic              mem_wr_en,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              shd_valid,
  input  logic [REG_W-1:0]  shd_dst,
  input  logic [DATA_W-1:0] shd_data,
  output logic [DATA_W-1:0] operand,
  output cpu_pkg::fwd_sel_e sel,
  output logic              hazard
);
  import cpu_pkg::*;

  // Register 0 and unused operands never match any writer.
  logic live;
  logic ex_hit, mem_hit, wb_hit, shd_hit;

  assign live    = src_en && (src != '0);
  assign ex_hit  = live && ex_valid && ex_wr_en && (ex_dst == src);
  assign mem_hit = live && mem_valid && mem_wr_en && (mem_dst == src);
  assign wb_hit  = live && wb_valid && (wb_dst == src);
  assign shd_hit = live && shd_valid && (shd_dst == src);

`ifndef OPERAND_FWD_EN
  logic unused_is_load;
  assign unused_is_load = ex_is_load;
`endif

  always_comb begin
    sel    = FWD_RF;
    hazard = 1'b0;
`ifdef OPERAND_FWD_EN
    if (ex_hit && !ex_is_load) sel = FWD_EX;
    else if (mem_hit)          sel = FWD_MEM;
    else if (wb_hit)           sel = FWD_WB;
    else if (shd_hit)          sel = FWD_SHD;
    hazard = ex_hit && ex_is_load;
`else
    hazard = ex_hit || mem_hit || wb_hit || shd_hit;
`endif
    unique case (sel)
      FWD_EX:  operand = ex_data;
      FWD_MEM: operand = mem_data;
      FWD_WB:  operand = wb_data;
      FWD_SHD: operand = shd_data;
      default: operand = rf_data;
    endcase
    if (src == '0) operand = '0;
  end

endmodule

// File: rtl/operand_fwd_stage.sv
// Decode-to-execute operand stage. Captures the register-file read buses,
// overrides them with in-flight results, detects load-use hazards and
// presents a registered operand pair to execute under valid/ready.
// Build option: OPERAND_FWD_EN (see fwd_select) enables forwarding.
// Ports:
//   clk, rst_n (async, active low)
//   id_*            decode-stage instruction, sources and RF read data
//   ex_alu_result   combinational result of the instruction held in EX
//   mem_*, wb_*     later pipeline writers (wb_* equals the RF write port)
//   ex_ready, flush execute handshake / kill of the capture
//   id_stall        hold decode (combinational)
//   ex_*            registered operand pair and control
module operand_fwd_stage #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_en,
  input  logic              id_rt_en,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_valid,
  input  logic              mem_wr_en,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_wr_en,
  output logic              ex_is_load
);
  import cpu_pkg::*;

  // One-cycle copy of the write-back port: covers the register file
  // committing its write one cycle after the request.
  logic              shd_valid;
  logic [REG_W-1:0]  shd_dst;
  logic [DATA_W-1:0] shd_data;

  logic [DATA_W-1:0] op_a, op_b;
  fwd_sel_e          sel_a, sel_b;
  logic              haz_a, haz_b, hazard;

  logic unused_sel;
  assign unused_sel = ^{sel_a, sel_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_valid <= 1'b0;
      shd_dst   <= '0;
      shd_data  <= '0;
    end else begin
      shd_valid <= wb_valid && (wb_dst != '0);
      shd_dst   <= wb_dst;
      shd_data  <= wb_data;
    end
  end

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src(id_rs), .src_en(id_rs_en), .rf_data(rf_rd1),
    .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_dst(ex_dst), .ex_data(ex_alu_result),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .shd_valid(shd_valid), .shd_dst(shd_dst), .shd_data(shd_data),
    .operand(op_a), .sel(sel_a), .hazard(haz_a)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src(id_rt), .src_en(id_rt_en), .rf_data(rf_rd2),
    .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_dst(ex_dst), .ex_data(ex_alu_result),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .shd_valid(shd_valid), .shd_dst(shd_dst), .shd_data(shd_data),
    .operand(op_b), .sel(sel_b), .hazard(haz_b)
  );

  assign hazard   = haz_a || haz_b;
  assign id_stall = id_valid && (hazard || (ex_valid && !ex_ready));

  // Priority: flush, then hold while execute back-pressures, then bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_op_a    <= '0;
      ex_op_b    <= '0;
      ex_dst     <= '0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_valid && !ex_ready) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid   <= id_valid;
      ex_op_a    <= op_a;
      ex_op_b    <= op_b;
      ex_dst     <= id_dst;
      ex_wr_en   <= id_wr_en;
      ex_is_load <= id_is_load;
    end
  end

endmodule

// File: tb/tb_operand_fwd_stage.sv
module tb_operand_fwd_stage;

  logic        clk, rst_n;
  logic        id_valid, id_rs_en, id_rt_en, id_wr_en, id_is_load;
  logic [4:0]  id_rs, id_rt, id_dst, mem_dst, wb_dst, ex_dst;
  logic [31:0] rf_rd1, rf_rd2, ex_alu_result, mem_data, wb_data, ex_op_a, ex_op_b;
  logic        mem_valid, mem_wr_en, wb_valid, ex_ready, flush;
  logic        id_stall, ex_valid, ex_wr_en, ex_is_load;

  int passed = 0;
  int total  = 0;

  operand_fwd_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .ex_alu_result(ex_alu_result),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_dst(ex_dst), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_en = 0; id_rt_en = 0;
    rf_rd1 = 0; rf_rd2 = 0; id_dst = 0; id_wr_en = 0; id_is_load = 0;
    ex_alu_result = 0; mem_valid = 0; mem_wr_en = 0; mem_dst = 0; mem_data = 0;
    wb_valid = 0; wb_dst = 0; wb_data = 0; ex_ready = 1; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #12;
    total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ex_valid); else passed++;
    total++; if (ex_op_a !== 32'h0) $display("FAIL reset_op_a got %h want 0", ex_op_a); else passed++;
    total++; if (ex_op_b !== 32'h0) $display("FAIL reset_op_b got %h want 0", ex_op_b); else passed++;
    total++; if ({ex_dst, ex_wr_en, ex_is_load} !== 7'h0) $display("FAIL reset_ctrl got %h want 0", {ex_dst, ex_wr_en, ex_is_load}); else passed++;
    total++; if (id_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", id_stall); else passed++;
    @(negedge clk) rst_n = 1;
    tick();
  endtask

  task automatic test_fwd_ex();
    clear_inputs();
    id_valid = 1; id_dst = 5; id_wr_en = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_rs = 5; id_rs_en = 1; rf_rd1 = 32'hDEAD;
    ex_alu_result = 32'h11; id_dst = 6; id_wr_en = 1;
    #1;
`ifdef OPERAND_FWD_EN
    total++; if (id_stall !== 1'b0) $display("FAIL ex_fwd_stall got %b want 0", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b1) $display("FAIL ex_fwd_valid got %b want 1", ex_valid); else passed++;
    total++; if (ex_op_a !== 32'h11) $display("FAIL ex_fwd_op_a got %h want 11", ex_op_a); else passed++;
`else
    total++; if (id_stall !== 1'b1) $display("FAIL ex_nofwd_stall got %b want 1", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL ex_nofwd_bubble got %b want 0", ex_valid); else passed++;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL ex_nofwd_release got %b want 0", id_stall); else passed++;
    tick();
    total++; if (ex_op_a !== 32'hDEAD) $display("FAIL ex_nofwd_op_a got %h want dead", ex_op_a); else passed++;
`endif
    total++; if (ex_dst !== 5'd6) $display("FAIL ex_dst got %0d want 6", ex_dst); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_dst = 7; id_wr_en = 1; id_is_load = 1;
    tick();
    total++; if (ex_is_load !== 1'b1) $display("FAIL lu_is_load got %b want 1", ex_is_load); else passed++;
    clear_inputs();
    id_valid = 1; id_rt = 7; id_rt_en = 1; rf_rd2 = 32'h1234; id_dst = 8; id_wr_en = 1;
    #1;
    total++; if (id_stall !== 1'b1) $display("FAIL lu_stall got %b want 1", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble got %b want 0", ex_valid); else passed++;
    mem_valid = 1; mem_wr_en = 1; mem_dst = 7; mem_data = 32'hCAFE;
    #1;
`ifdef OPERAND_FWD_EN
    total++; if (id_stall !== 1'b0) $display("FAIL lu_one_bubble got %b want 0", id_stall); else passed++;
    tick();
`else
    total++; if (id_stall !== 1'b1) $display("FAIL lu_mem_stall got %b want 1", id_stall); else passed++;
    tick();
    mem_valid = 0; wb_valid = 1; wb_dst = 7; wb_data = 32'hCAFE;
    #1;
    total++; if (id_stall !== 1'b1) $display("FAIL lu_wb_stall got %b want 1", id_stall); else passed++;
    tick();
    wb_valid = 0; rf_rd2 = 32'hCAFE;
    #1;
    total++; if (id_stall !== 1'b1) $display("FAIL lu_shd_stall got %b want 1", id_stall); else passed++;
    tick();
    total++; if (id_stall !== 1'b0) $display("FAIL lu_clear got %b want 0", id_stall); else passed++;
    tick();
`endif
    total++; if (ex_valid !== 1'b1) $display("FAIL lu_valid got %b want 1", ex_valid); else passed++;
    total++; if (ex_op_b !== 32'hCAFE) $display("FAIL lu_op_b got %h want cafe", ex_op_b); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_shadow();
    clear_inputs();
    wb_valid = 1; wb_dst = 3; wb_data = 32'h42;
    tick();
    clear_inputs();
    id_valid = 1; id_rs = 3; id_rs_en = 1; rf_rd1 = 32'h0;
    #1;
`ifdef OPERAND_FWD_EN
    total++; if (id_stall !== 1'b0) $display("FAIL shd_stall got %b want 0", id_stall); else passed++;
    tick();
`else
    total++; if (id_stall !== 1'b1) $display("FAIL shd_nofwd_stall got %b want 1", id_stall); else passed++;
    tick();
    rf_rd1 = 32'h42;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL shd_nofwd_release got %b want 0", id_stall); else passed++;
    tick();
`endif
    total++; if (ex_op_a !== 32'h42) $display("FAIL shd_op_a got %h want 42", ex_op_a); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_zero_src();
    clear_inputs();
    id_valid = 1; id_rs = 0; id_rs_en = 1; rf_rd1 = 32'h55;
    id_rt = 4; id_rt_en = 0; rf_rd2 = 32'h77;
    mem_valid = 1; mem_wr_en = 1; mem_dst = 0; mem_data = 32'hFF;
    wb_valid = 1; wb_dst = 4; wb_data = 32'h99;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL zero_stall got %b want 0", id_stall); else passed++;
    tick();
    total++; if (ex_op_a !== 32'h0) $display("FAIL zero_op_a got %h want 0", ex_op_a); else passed++;
    total++; if (ex_op_b !== 32'h77) $display("FAIL disabled_op_b got %h want 77", ex_op_b); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_valid = 1; id_dst = 12; id_wr_en = 1;
    wb_valid = 1; wb_dst = 12; wb_data = 32'h4;
    tick();
    clear_inputs();
    id_valid = 1; id_rs = 12; id_rs_en = 1; rf_rd1 = 32'hBAD;
    ex_alu_result = 32'h1;
    mem_valid = 1; mem_wr_en = 1; mem_dst = 12; mem_data = 32'h2;
    wb_valid = 1; wb_dst = 12; wb_data = 32'h3;
    #1;
`ifdef OPERAND_FWD_EN
    tick();
    total++; if (ex_op_a !== 32'h1) $display("FAIL prio_ex got %h want 1", ex_op_a); else passed++;
    tick();
    total++; if (ex_op_a !== 32'h2) $display("FAIL prio_mem got %h want 2", ex_op_a); else passed++;
    mem_valid = 0; wb_data = 32'h5;
    tick();
    total++; if (ex_op_a !== 32'h5) $display("FAIL prio_wb got %h want 5", ex_op_a); else passed++;
    wb_valid = 0;
    tick();
    total++; if (ex_op_a !== 32'h5) $display("FAIL prio_shd got %h want 5", ex_op_a); else passed++;
    tick();
    total++; if (ex_op_a !== 32'hBAD) $display("FAIL prio_rf got %h want bad", ex_op_a); else passed++;
`else
    total++; if (id_stall !== 1'b1) $display("FAIL b2b_stall got %b want 1", id_stall); else passed++;
    tick();
    total++; if (id_stall !== 1'b1) $display("FAIL b2b_stall_hold got %b want 1", id_stall); else passed++;
    total++; if (ex_valid !== 1'b0) $display("FAIL b2b_bubble got %b want 0", ex_valid); else passed++;
`endif
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_ready_stall();
    clear_inputs();
    id_valid = 1; id_rs = 1; id_rs_en = 1; rf_rd1 = 32'hA1; id_dst = 10; id_wr_en = 1;
    tick();
    ex_ready = 0; id_rs = 2; rf_rd1 = 32'hB2; id_dst = 11;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_stall !== 1'b1) $display("FAIL hold_stall[%0d] got %b want 1", i, id_stall); else passed++;
      tick();
      total++; if ({ex_valid, ex_dst, ex_op_a} !== {1'b1, 5'd10, 32'hA1})
        $display("FAIL hold_fields[%0d] got %b/%0d/%h want 1/10/a1", i, ex_valid, ex_dst, ex_op_a); else passed++;
    end
    flush = 1;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", ex_valid); else passed++;
    flush = 0;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL flush_stall got %b want 0", id_stall); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    id_valid = 1; id_rs = 1; id_rs_en = 1; rf_rd1 = 32'h77;
    id_dst = 13; id_wr_en = 1; id_is_load = 1;
    wb_valid = 1; wb_dst = 14; wb_data = 32'hEE;
    tick();
    wb_valid = 0;
    #2 rst_n = 0;
    #1;
    total++; if ({ex_valid, ex_is_load, ex_dst} !== 7'h0) $display("FAIL rst_mid_ctrl got %h want 0", {ex_valid, ex_is_load, ex_dst}); else passed++;
    total++; if (ex_op_a !== 32'h0) $display("FAIL rst_mid_op_a got %h want 0", ex_op_a); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL rst_no_capture got %b want 0", ex_valid); else passed++;
    @(negedge clk) rst_n = 1;
    id_is_load = 0; id_rs_en = 0; id_rt = 14; id_rt_en = 1; rf_rd2 = 32'h0; id_dst = 15;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL rst_shd_stall got %b want 0", id_stall); else passed++;
    tick();
    total++; if ({ex_valid, ex_op_b} !== {1'b1, 32'h0}) $display("FAIL rst_shd_op_b got %b/%h want 1/0", ex_valid, ex_op_b); else passed++;
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_shadow();
    test_zero_src();
    test_back_to_back();
    test_ready_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
